fir_out_decimator: RTL and testbench
====================================

Name: fir_out_decimator

Overview:
- Downstream stage of the 9-tap FIR filter. Consumes the filter's 18-bit unsigned output every cycle.
- Keeps one sample in DECIM and scales it to OUT_W bits by a right shift with saturation.
- Buffers scaled samples in a small FIFO and presents them on a valid/ready interface to the next consumer (DAC/serializer or bus bridge).

Parameters:
- IN_W, 18, input sample width; matches the FIR output.
- OUT_W, 8, output sample width.
- SHIFT, 10, right-shift applied before saturation, range 0..IN_W-1.
- DECIM, 2, decimation ratio, >=1; 1 keeps every sample.
- DEPTH, 4, FIFO entries; power of 2, >=2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_data  in  IN_W  FIR output sample, unsigned
- in_valid  in  1  in_data is a new sample this cycle; tie high when the FIR runs every clock
- out_data  out  OUT_W  FIFO head sample; unspecified when out_valid=0
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head this cycle
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- ovf  out  1  sticky: a kept sample was dropped because the FIFO was full
- ovf_clr  in  1  clears ovf

Behaviour:
- Reset (rst=1 at a clk edge):
  - phase=0, stage register invalid, FIFO empty.
  - out_valid=0, fifo_level=0, ovf=0.
  - rst overrides all other inputs, including mid-burst; any buffered samples are discarded.
- Decimation counter `phase`, range 0..DECIM-1:
  - Advances only on in_valid=1 and wraps from DECIM-1 to 0.
  - A sample is kept when in_valid=1 and phase==0, so the first valid sample after reset is kept.
- Scale stage, one register:
  - s = in_data >> SHIFT, computed at IN_W bits.
  - If s > 2^OUT_W-1, the result is 2^OUT_W-1; otherwise it is s[OUT_W-1:0].
  - Registered together with a stage-valid bit.
- FIFO push:
  - Occurs in the cycle after the stage register loads (stage valid).
  - A push with the FIFO full and no simultaneous pop is dropped, and ovf is set.
- Latency: a kept sample at in_valid cycle N is stored at the end of cycle N+1 and appears on out_data with out_valid=1 in cycle N+2.
- Pop: occurs when out_valid && out_ready. out_ready while empty is ignored.
- Simultaneous push and pop:
  - Full: push is accepted and level stays at DEPTH; no ovf.
  - Empty: the pushed sample is not visible until the next cycle; no bypass.
- Pointers are log2(DEPTH) bits and wrap naturally. fifo_level = writes - reads.
- ovf:
  - Set has priority over ovf_clr in the same cycle.
  - ovf_clr otherwise clears it the next cycle.
- in_valid=0 freezes phase; the stage register goes invalid.

Optional Feature:
- Macro FIR_DEC_ROUND_EN.
- When defined: round half-up before shifting, s = (in_data + 2^(SHIFT-1)) >> SHIFT.
  - The sum is computed at IN_W+1 bits so there is no wrap.
  - Saturation is then applied.
  - Ignored when SHIFT=0.
- When undefined: truncation, as defined above.
- Latency is identical in both builds.

Decomposition:
- Package fir_pkg:
  - FIR_OUT_W=18 constant, shared with the FIR.
  - Default OUT_W, SHIFT and DECIM constants.
  - A sat_shift function performing shift and saturation.
- Sub-module fir_sync_fifo, parameterized on width and DEPTH:
  - Ports: push/din, pop/dout, full, empty, level.
  - The decimator owns phase, the scale stage, ovf and drop logic.

Test Plan:
- Defaults, in_valid=1, in_data=188955 constant, out_ready=1 -> first out_valid at cycle 2 with out_data=184 (185 with FIR_DEC_ROUND_EN); then one output every 2 cycles.
- in_data=18'h3FFFF -> out_data=255 (saturated with rounding, truncated 255 without); in_data=1023 -> 0 (1 with rounding).
- DECIM=3, samples 1024,2048,3072,4096,5120,6144 -> outputs 1,4 only; in_valid gaps do not advance phase.
- out_ready=0, DECIM=1, 6 kept samples -> fifo_level saturates at 4, ovf=1, and the first 4 samples pop in order; ovf_clr -> ovf=0 next cycle.
- FIFO full with out_ready=1 and a push in the same cycle -> level stays 4, ovf stays 0, order is preserved.
- rst asserted with level=3 -> next cycle out_valid=0, fifo_level=0, ovf=0; the first sample after rst is kept (phase=0).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the FIR chain and the shift-with-saturation helper used by its output stage.
package fir_pkg;

   localparam int FIR_OUT_W = 18;
   localparam int DEC_OUT_W = 8;
   localparam int DEC_SHIFT = 10;
   localparam int DEC_DECIM = 2;
   localparam int DEC_DEPTH = 4;

   // Operates on a 32-bit container so callers with any IN_W up to 31 can share it.
   function automatic logic [31:0] sat_shift(input logic [31:0] val,
                                             input int unsigned shift,
                                             input int unsigned outW);
      logic [31:0] s;
      logic [31:0] maxVal;
      s      = val >> shift;
      maxVal = (32'd1 << outW) - 32'd1;
      return (s > maxVal) ? maxVal : s;
   endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Small synchronous FIFO with show-ahead head output; a push while full is accepted only alongside a pop.
module fir_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q, wrPtr_d;
   logic [AW-1:0]    rdPtr_q, rdPtr_d;
   logic [AW:0]      level_q, level_d;
   logic             pushOk, popOk;

   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign dout_o  = mem_q[rdPtr_q];

   assign popOk  = pop_i && !empty_o;
   assign pushOk = push_i && (!full_o || popOk);

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      level_d = level_q;
      if (pushOk) wrPtr_d = wrPtr_q + 1'b1;
      if (popOk)  rdPtr_d = rdPtr_q + 1'b1;
      if (pushOk && !popOk)      level_d = level_q + 1'b1;
      else if (popOk && !pushOk) level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         level_q <= level_d;
      end
   end

   // Storage needs no reset: level gates every read that matters.
   always_ff @(posedge clk) begin
      if (pushOk) mem_q[wrPtr_q] <= din_i;
   end

endmodule

// File: rtl/fir_out_decimator.sv
// FIR output stage: decimate by DECIM, shift/saturate to OUT_W, buffer in a FIFO behind valid/ready.
// Define FIR_DEC_ROUND_EN to round half-up before the shift instead of truncating.
module fir_out_decimator
   import fir_pkg::*;
#(
   parameter int IN_W  = FIR_OUT_W,
   parameter int OUT_W = DEC_OUT_W,
   parameter int SHIFT = DEC_SHIFT,
   parameter int DECIM = DEC_DECIM,
   parameter int DEPTH = DEC_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [IN_W-1:0]         in_data,
   input  logic                    in_valid,
   output logic [OUT_W-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic                    ovf,
   input  logic                    ovf_clr
);

   localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

`ifdef FIR_DEC_ROUND_EN
   localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [IN_W:0] RND = (SHIFT > 0) ? ((IN_W+1)'(1) << RND_SH) : '0;
`else
   localparam logic [IN_W:0] RND = '0;
`endif

   logic [PH_W-1:0]  phase_q, phase_d;
   logic [OUT_W-1:0] stageData_q;
   logic             stageValid_q;
   logic             ovf_q, ovf_d;
   logic             keep, pop, drop, full, empty;
   logic [IN_W:0]    sum;

   assign keep = in_valid && (phase_q == '0);
   assign sum  = {1'b0, in_data} + RND;

   always_comb begin
      phase_d = phase_q;
      if (in_valid) phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q      <= '0;
         stageValid_q <= 1'b0;
         stageData_q  <= '0;
      end else begin
         phase_q      <= phase_d;
         stageValid_q <= keep;
         if (keep) stageData_q <= OUT_W'(sat_shift(32'(sum), SHIFT, OUT_W));
      end
   end

   assign out_valid = !empty;
   assign pop       = !empty && out_ready;
   // A same-cycle pop frees the slot, so only a full FIFO with no pop loses the sample.
   assign drop      = stageValid_q && full && !pop;

   always_comb begin
      ovf_d = ovf_q;
      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;

   fir_sync_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (stageValid_q),
      .din_i   (stageData_q),
      .pop_i   (pop),
      .dout_o  (out_data),
      .full_o  (full),
      .empty_o (empty),
      .level_o (fifo_level)
   );

endmodule

// File: tb/tb_fir_out_decimator.sv
// Self-checking bench for fir_out_decimator: three instances (DECIM=2,3,1) share stimulus and a queue-style reference model.
module tb_fir_out_decimator;

   localparam int SHIFT = 10;
   localparam int NINST = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        ovf_clr = 1'b0;
   logic [17:0] in_data = '0;

   logic [7:0]  outData  [NINST];
   logic        outValid [NINST];
   logic [2:0]  level    [NINST];
   logic        ovfO     [NINST];

   int checks = 0;
   int failures = 0;

   int  decimOf   [NINST];
   int  mFifo     [NINST][4];
   int  mCnt      [NINST];
   bit  mOvf      [NINST];
   bit  mPend     [NINST];
   int  mPendVal  [NINST];
   int  mValidCnt [NINST];
   int  popped[$];

   typedef struct {
      int din;
      int expTrunc;
      int expRound;
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   fir_out_decimator #(.DECIM(2)) dut0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .out_data(outData[0]), .out_valid(outValid[0]), .out_ready(out_ready),
      .fifo_level(level[0]), .ovf(ovfO[0]), .ovf_clr(ovf_clr));

   fir_out_decimator #(.DECIM(3)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .out_data(outData[1]), .out_valid(outValid[1]), .out_ready(out_ready),
      .fifo_level(level[1]), .ovf(ovfO[1]), .ovf_clr(ovf_clr));

   fir_out_decimator #(.DECIM(1)) dut2 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .out_data(outData[2]), .out_valid(outValid[2]), .out_ready(out_ready),
      .fifo_level(level[2]), .ovf(ovfO[2]), .ovf_clr(ovf_clr));

   function automatic int scaleRef(int x);
      int r;
      r = x;
`ifdef FIR_DEC_ROUND_EN
      r = x + (1 << (SHIFT - 1));
`endif
      r = r >> SHIFT;
      if (r > 255) r = 255;
      return r;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Reference: a list of buffered samples, a one-cycle delay for kept samples, and a count of valid inputs.
   task automatic modelStep();
      for (int k = 0; k < NINST; k++) begin
         if (rst) begin
            mCnt[k] = 0; mOvf[k] = 0; mPend[k] = 0; mValidCnt[k] = 0;
         end else begin
            bit dropped;
            dropped = 0;
            if (mCnt[k] > 0 && out_ready) begin
               for (int j = 0; j < 3; j++) mFifo[k][j] = mFifo[k][j+1];
               mCnt[k]--;
            end
            if (mPend[k]) begin
               if (mCnt[k] == 4) dropped = 1;
               else begin
                  mFifo[k][mCnt[k]] = mPendVal[k];
                  mCnt[k]++;
               end
            end
            if (dropped)      mOvf[k] = 1;
            else if (ovf_clr) mOvf[k] = 0;
            mPend[k]    = in_valid && (mValidCnt[k] % decimOf[k] == 0);
            mPendVal[k] = scaleRef(int'(in_data));
            if (in_valid) mValidCnt[k]++;
         end
      end
   endtask

   task automatic modelCheck();
      for (int k = 0; k < NINST; k++) begin
         checkOutput($sformatf("model out_valid[%0d]", k), int'(outValid[k]), (mCnt[k] > 0) ? 1 : 0);
         checkOutput($sformatf("model fifo_level[%0d]", k), int'(level[k]), mCnt[k]);
         checkOutput($sformatf("model ovf[%0d]", k), int'(ovfO[k]), int'(mOvf[k]));
         if (mCnt[k] > 0)
            checkOutput($sformatf("model out_data[%0d]", k), int'(outData[k]), mFifo[k][0]);
      end
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      modelCheck();
   endtask

   task automatic stepCollect(input int k);
      if (outValid[k] && out_ready) popped.push_back(int'(outData[k]));
      applyStimulus();
   endtask

   task automatic applyReset();
      rst = 1; in_valid = 0; out_ready = 0; ovf_clr = 0;
      applyStimulus();
      rst = 0;
   endtask

   function automatic int expOf(vec_t v);
`ifdef FIR_DEC_ROUND_EN
      return v.expRound;
`else
      return v.expTrunc;
`endif
   endfunction

   initial begin
      int expV[6];
      int validPat[10];
      int j;

      decimOf[0] = 2; decimOf[1] = 3; decimOf[2] = 1;
      for (int k = 0; k < NINST; k++) begin
         mCnt[k] = 0; mOvf[k] = 0; mPend[k] = 0; mPendVal[k] = 0; mValidCnt[k] = 0;
      end

      vecs[0] = '{188955, 184, 185};
      vecs[1] = '{262143, 255, 255};
      vecs[2] = '{1023,   0,   1};
      vecs[3] = '{0,      0,   0};
      vecs[4] = '{1024,   1,   1};
      vecs[5] = '{261120, 255, 255};
      vecs[6] = '{261119, 254, 255};
      vecs[7] = '{512,    0,   1};
      vecs[8] = '{511,    0,   0};

      // Reset state and first-output latency with a constant stream.
      applyReset();
      for (int k = 0; k < NINST; k++) begin
         checkOutput("reset out_valid", int'(outValid[k]), 0);
         checkOutput("reset fifo_level", int'(level[k]), 0);
         checkOutput("reset ovf", int'(ovfO[k]), 0);
      end
      in_valid = 1; in_data = 18'd188955; out_ready = 1;
      expV = '{0, 0, 1, 0, 1, 0};
      for (int i = 0; i < 6; i++) begin
         checkOutput($sformatf("const out_valid c%0d", i), int'(outValid[0]), expV[i]);
         if (expV[i] == 1) checkOutput($sformatf("const out_data c%0d", i), int'(outData[0]), expOf(vecs[0]));
         applyStimulus();
      end

      // Scaling table on the DECIM=1 instance.
      applyReset();
      out_ready = 1;
      for (int i = 0; i < 9; i++) begin
         in_data = 18'(vecs[i].din); in_valid = 1;
         applyStimulus();
         in_valid = 0;
         applyStimulus();
         checkOutput($sformatf("table out_valid %0d", vecs[i].din), int'(outValid[2]), 1);
         checkOutput($sformatf("table out_data %0d", vecs[i].din), int'(outData[2]), expOf(vecs[i]));
      end

      // DECIM=3 with in_valid gaps.
      applyReset();
      out_ready = 1;
      validPat = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 0};
      popped.delete();
      j = 0;
      for (int i = 0; i < 14; i++) begin
         if (i < 10 && validPat[i] == 1) begin
            j++;
            in_valid = 1; in_data = 18'(1024 * j);
         end else begin
            in_valid = 0; in_data = 18'h3FFFF;
         end
         stepCollect(1);
      end
      checkOutput("decim3 count", popped.size(), 2);
      if (popped.size() >= 2) begin
         checkOutput("decim3 first", popped[0], 1);
         checkOutput("decim3 second", popped[1], 4);
      end

      // Overflow with a stalled consumer, then in-order drain and ovf_clr.
      applyReset();
      for (int i = 0; i < 6; i++) begin
         in_valid = 1; in_data = 18'(1024 * (i + 1));
         applyStimulus();
      end
      in_valid = 0;
      applyStimulus();
      applyStimulus();
      checkOutput("ovf level", int'(level[2]), 4);
      checkOutput("ovf set", int'(ovfO[2]), 1);
      out_ready = 1;
      popped.delete();
      for (int i = 0; i < 6; i++) stepCollect(2);
      checkOutput("ovf drain count", popped.size(), 4);
      for (int i = 0; i < popped.size() && i < 4; i++)
         checkOutput($sformatf("ovf drain %0d", i), popped[i], i + 1);
      checkOutput("ovf sticky", int'(ovfO[2]), 1);
      ovf_clr = 1;
      applyStimulus();
      ovf_clr = 0;
      checkOutput("ovf cleared", int'(ovfO[2]), 0);

      // Full FIFO with simultaneous push and pop.
      applyReset();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1; in_data = 18'(1024 * (10 + i));
         applyStimulus();
      end
      checkOutput("fullpp level before", int'(level[2]), 4);
      in_valid = 0; out_ready = 1;
      popped.delete();
      stepCollect(2);
      checkOutput("fullpp level", int'(level[2]), 4);
      checkOutput("fullpp ovf", int'(ovfO[2]), 0);
      for (int i = 0; i < 6; i++) stepCollect(2);
      checkOutput("fullpp count", popped.size(), 5);
      for (int i = 0; i < popped.size() && i < 5; i++)
         checkOutput($sformatf("fullpp order %0d", i), popped[i], 10 + i);

      // Reset while holding data and a sticky overflow.
      applyReset();
      for (int i = 0; i < 6; i++) begin
         in_valid = 1; in_data = 18'(1024 * (i + 1));
         applyStimulus();
      end
      in_valid = 0;
      applyStimulus();
      applyStimulus();
      out_ready = 1;
      applyStimulus();
      out_ready = 0;
      checkOutput("midrst level before", int'(level[2]), 3);
      checkOutput("midrst ovf before", int'(ovfO[2]), 1);
      rst = 1; in_valid = 1; in_data = 18'd5000;
      applyStimulus();
      rst = 0;
      checkOutput("midrst out_valid", int'(outValid[2]), 0);
      checkOutput("midrst fifo_level", int'(level[2]), 0);
      checkOutput("midrst ovf", int'(ovfO[2]), 0);
      in_valid = 1; in_data = 18'd2048; out_ready = 1;
      applyStimulus();
      in_valid = 0;
      applyStimulus();
      checkOutput("midrst first kept valid", int'(outValid[0]), 1);
      checkOutput("midrst first kept data", int'(outData[0]), 2);

      // Randomized traffic with varying consumer throughput.
      applyReset();
      for (int i = 0; i < 3000; i++) begin
         int readyPct;
         readyPct  = ((i / 200) % 3 == 0) ? 20 : 85;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 18'($urandom_range(0, 262143));
         out_ready = ($urandom_range(0, 99) < readyPct);
         ovf_clr   = ($urandom_range(0, 15) == 0);
         rst       = ($urandom_range(0, 499) == 0);
         applyStimulus();
      end
      rst = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
